// File: rtl/seg_display_scheduler.sv
// rtl/seg_display_scheduler.sv - frame-synchronous round-robin owner of the 8-digit seven-segment display
module seg_display_scheduler #(
  parameter int SCAN_DIV    = 50000,
  parameter int HOLD_FRAMES = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req,
  input  logic [223:0] frame_in,
  output logic [3:0]   grant,
  output logic         busy,
  output logic [7:0]   segout,
  output logic [2:0]   scanout,
  output logic         frame_done
);

  localparam logic [0:0]  ST_IDLE   = 1'b0;
  localparam logic [0:0]  ST_OWN    = 1'b1;
  localparam logic [19:0] PRESC_MAX = 20'(SCAN_DIV - 1);
  localparam logic [7:0]  HOLD_MAX  = 8'(HOLD_FRAMES - 1);

  logic [19:0] presc_q, presc_d;
  logic [2:0]  scan_q, scan_d;
  logic [7:0]  seg_q, seg_d;
  logic [3:0]  grant_q, grant_d;
  logic        fdone_q, fdone_d;
  logic [1:0]  rr_q, rr_d;
  logic [7:0]  hold_q, hold_d;
  logic [55:0] buf_q, buf_d;
  logic [0:0]  state_q, state_d;
  logic [1:0]  owner_q, owner_d;

  logic        tick;
  logic        fb;
  logic [2:0]  pick_idle;
  logic [2:0]  pick_next;
  logic [3:0]  others;

  // Returns {found, index} of the first set bit of r, scanning start, start+1, ... mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] j;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      j = start + 2'(i);
      if (r[j]) res = {1'b1, j};
    end
    return res;
  endfunction

  assign tick      = (presc_q == PRESC_MAX);
  assign fb        = tick && (scan_q == 3'd7);
  assign others    = req & ~(4'b0001 << owner_q);
  assign pick_idle = rr_pick(req, rr_q);
  assign pick_next = rr_pick(others, owner_q + 2'd1);

  // Ownership decisions, taken only at frame boundaries so a frame is never split.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    buf_d   = buf_q;
    if (fb) begin
      case (state_q)
        ST_IDLE: begin
          if (pick_idle[2]) begin
            state_d = ST_OWN;
            owner_d = pick_idle[1:0];
            grant_d = 4'b0001 << pick_idle[1:0];
            buf_d   = frame_in[56*pick_idle[1:0] +: 56];
            hold_d  = 8'd0;
          end
        end
        ST_OWN: begin
          if (!req[owner_q] || (hold_q == HOLD_MAX && pick_next[2])) begin
            rr_d   = owner_q + 2'd1;
            hold_d = 8'd0;
            if (pick_next[2]) begin
              owner_d = pick_next[1:0];
              grant_d = 4'b0001 << pick_next[1:0];
              buf_d   = frame_in[56*pick_next[1:0] +: 56];
            end else begin
              state_d = ST_IDLE;
              grant_d = 4'b0000;
            end
          end else begin
            buf_d = frame_in[56*owner_q +: 56];
            if (hold_q != HOLD_MAX) hold_d = hold_q + 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          grant_d = 4'b0000;
        end
      endcase
    end
  end

  // Digit scan; segout looks at next-state buffer so frame digit 0 comes from the fresh latch.
  always_comb begin
    presc_d = tick ? 20'd0 : presc_q + 20'd1;
    scan_d  = tick ? scan_q + 3'd1 : scan_q;
    fdone_d = fb;
    seg_d   = seg_q;
    if (tick) begin
      if (state_d == ST_OWN) seg_d = {1'b1, buf_d[7*scan_d +: 7]};
      else                   seg_d = 8'hFF;
    end
  end

  // State registers with asynchronous reset to a blank, idle display.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= 20'd0;
      scan_q  <= 3'd0;
      seg_q   <= 8'hFF;
      grant_q <= 4'b0000;
      fdone_q <= 1'b0;
      rr_q    <= 2'd0;
      hold_q  <= 8'd0;
      buf_q   <= {56{1'b1}};
      state_q <= ST_IDLE;
      owner_q <= 2'd0;
    end else begin
      presc_q <= presc_d;
      scan_q  <= scan_d;
      seg_q   <= seg_d;
      grant_q <= grant_d;
      fdone_q <= fdone_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      buf_q   <= buf_d;
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  assign grant      = grant_q;
  assign busy       = |grant_q;
  assign segout     = seg_q;
  assign scanout    = scan_q;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// tb/tb_seg_display_scheduler.sv - directed vector bench for seg_display_scheduler
module tb_seg_display_scheduler;

  localparam int SD = 4;
  localparam int HF = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req = 4'b0000;
  logic [223:0] frame_in = '1;
  logic [3:0]   grant;
  logic         busy;
  logic [7:0]   segout;
  logic [2:0]   scanout;
  logic         frame_done;

  seg_display_scheduler #(.SCAN_DIV(SD), .HOLD_FRAMES(HF)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .frame_in(frame_in),
    .grant(grant),
    .busy(busy),
    .segout(segout),
    .scanout(scanout),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] req;
    logic [3:0] grant;
    logic [2:0] scan;
    logic [7:0] seg;
    logic       fd;
  } vec_t;

  vec_t       tab_a[$];
  vec_t       tab_b[$];
  int         checks = 0;
  int         errors = 0;
  int         now = 0;
  logic [3:0] prev_grant = 4'b0000;

  function automatic vec_t mk(int c, logic [3:0] r, logic [3:0] g, logic [2:0] s, logic [7:0] sg, logic f);
    vec_t v;
    v.cyc = c; v.req = r; v.grant = g; v.scan = s; v.seg = sg; v.fd = f;
    return v;
  endfunction

  function automatic logic [6:0] pat(int r, int d, bit alt);
    int base;
    case (r)
      0: base = 'h40;
      1: base = alt ? 'h50 : 'h30;
      2: base = 'h20;
      default: base = 'h60;
    endcase
    return 7'(base | d);
  endfunction

  task automatic set_frames(bit alt);
    for (int r = 0; r < 4; r++)
      for (int d = 0; d < 8; d++)
        frame_in[56*r + 7*d +: 7] = pat(r, d, alt);
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, now, got, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      now++;
      if (grant !== prev_grant) begin
        check("grant_change_scan0", 32'(scanout), 32'd0);
        check("grant_change_fdone", 32'(frame_done), 32'd1);
        check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        check("busy_eq_or_grant", 32'(busy), 32'(|grant));
        prev_grant = grant;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    now = 0;
    prev_grant = grant;
  endtask

  task automatic run_vec(vec_t v);
    req = v.req;
    step(v.cyc - now);
    check($sformatf("grant@%0d", v.cyc), 32'(grant), 32'(v.grant));
    check($sformatf("busy@%0d", v.cyc), 32'(busy), 32'(|v.grant));
    check($sformatf("scan@%0d", v.cyc), 32'(scanout), 32'(v.scan));
    check($sformatf("seg@%0d", v.cyc), 32'(segout), 32'(v.seg));
    check($sformatf("fdone@%0d", v.cyc), 32'(frame_done), 32'(v.fd));
  endtask

  initial begin
    // Idle scan, late request granted at the second boundary, live refresh.
    tab_a.push_back(mk(0,  4'b0000, 4'b0000, 3'd0, 8'hFF, 1'b0));
    tab_a.push_back(mk(3,  4'b0000, 4'b0000, 3'd0, 8'hFF, 1'b0));
    tab_a.push_back(mk(4,  4'b0000, 4'b0000, 3'd1, 8'hFF, 1'b0));
    tab_a.push_back(mk(31, 4'b0000, 4'b0000, 3'd7, 8'hFF, 1'b0));
    tab_a.push_back(mk(32, 4'b0000, 4'b0000, 3'd0, 8'hFF, 1'b1));
    tab_a.push_back(mk(33, 4'b0000, 4'b0000, 3'd0, 8'hFF, 1'b0));
    tab_a.push_back(mk(40, 4'b0000, 4'b0000, 3'd2, 8'hFF, 1'b0));
    tab_a.push_back(mk(63, 4'b0001, 4'b0000, 3'd7, 8'hFF, 1'b0));
    tab_a.push_back(mk(64, 4'b0001, 4'b0001, 3'd0, 8'hC0, 1'b1));
    tab_a.push_back(mk(65, 4'b0001, 4'b0001, 3'd0, 8'hC0, 1'b0));
    tab_a.push_back(mk(68, 4'b0001, 4'b0001, 3'd1, 8'hC1, 1'b0));
    tab_a.push_back(mk(92, 4'b0001, 4'b0001, 3'd7, 8'hC7, 1'b0));
    tab_a.push_back(mk(96, 4'b0001, 4'b0001, 3'd0, 8'hC0, 1'b1));
    // Two requesters from reset: two-frame time slices, round-robin back to 0.
    tab_b.push_back(mk(0,   4'b0101, 4'b0000, 3'd0, 8'hFF, 1'b0));
    tab_b.push_back(mk(32,  4'b0101, 4'b0001, 3'd0, 8'hC0, 1'b1));
    tab_b.push_back(mk(95,  4'b0101, 4'b0001, 3'd7, 8'hC7, 1'b0));
    tab_b.push_back(mk(96,  4'b0101, 4'b0100, 3'd0, 8'hA0, 1'b1));
    tab_b.push_back(mk(100, 4'b0101, 4'b0100, 3'd1, 8'hA1, 1'b0));
    tab_b.push_back(mk(128, 4'b0101, 4'b0100, 3'd0, 8'hA0, 1'b1));
    tab_b.push_back(mk(159, 4'b0101, 4'b0100, 3'd7, 8'hA7, 1'b0));
    tab_b.push_back(mk(160, 4'b0101, 4'b0001, 3'd0, 8'hC0, 1'b1));
    tab_b.push_back(mk(172, 4'b0101, 4'b0001, 3'd3, 8'hC3, 1'b0));

    set_frames(1'b0);
    do_reset();
    foreach (tab_a[i]) run_vec(tab_a[i]);

    do_reset();
    foreach (tab_b[i]) run_vec(tab_b[i]);

    // Owner 0 drops its request mid-frame; its frame completes, then requester 2 takes over.
    req = 4'b0100;
    step(4);
    check("drop_grant@176", 32'(grant), 32'h1);
    check("drop_seg@176", 32'(segout), 32'hC4);
    while (now < 188) begin
      step(1);
      check("drop_busy", 32'(busy), 32'd1);
    end
    check("drop_grant@188", 32'(grant), 32'h1);
    check("drop_seg@188", 32'(segout), 32'hC7);
    step(4);
    check("drop_grant@192", 32'(grant), 32'h4);
    check("drop_seg@192", 32'(segout), 32'hA0);
    check("drop_scan@192", 32'(scanout), 32'd0);

    // Owner 1: a mid-frame pattern change only shows from the next frame.
    set_frames(1'b0);
    do_reset();
    req = 4'b0010;
    step(32);
    check("live_grant@32", 32'(grant), 32'h2);
    check("live_seg@32", 32'(segout), 32'hB0);
    step(20);
    check("live_seg@52", 32'(segout), 32'hB5);
    set_frames(1'b1);
    step(4);
    check("live_seg@56", 32'(segout), 32'hB6);
    step(4);
    check("live_seg@60", 32'(segout), 32'hB7);
    step(4);
    check("live_seg@64", 32'(segout), 32'hD0);
    check("live_grant@64", 32'(grant), 32'h2);
    step(4);
    check("live_seg@68", 32'(segout), 32'hD1);

    // Reset pulse while owning: outputs clear at once, re-grant one full frame after release.
    step(2);
    reset = 1'b1;
    #1;
    check("rst_seg", 32'(segout), 32'hFF);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_scan", 32'(scanout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    now = 0;
    prev_grant = grant;
    step(31);
    check("regrant_grant@31", 32'(grant), 32'h0);
    check("regrant_scan@31", 32'(scanout), 32'd7);
    step(1);
    check("regrant_grant@32", 32'(grant), 32'h2);
    check("regrant_seg@32", 32'(segout), 32'hD0);
    check("regrant_fdone@32", 32'(frame_done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_display_scheduler.md
Name: seg_display_scheduler

Overview:
- Shares the board's 8-digit multiplexed seven-segment display between four pattern-generating requesters.
- Generates the digit scan and grants the display to one requester per whole scan frame, using round-robin with a frame-count time slice.
- Latches the owner's 56-bit pattern once per frame, so digits never tear.
- Drives segout/scanout directly to the display pins, replacing per-pattern scan logic.

Parameters:
- SCAN_DIV, 50000: clk cycles per digit (the digit dwell); legal range 2..2^20.
- HOLD_FRAMES, 64: scan frames an owner keeps the display while another requester waits; legal range 1..255.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  display request per requester, level-sensitive.
- frame_in  input  224  patterns. Requester i occupies bits [56i+55:56i]. Digit d of requester i is [56i+7d+6:56i+7d], segments gfedcba, active-low.
- grant  output  4  one-hot current owner; 0 when idle.
- busy  output  1  high while any grant is asserted.
- segout  output  8  {dp, gfedcba}, active-low; dp is always 1.
- scanout  output  3  digit index being driven, 0..7.
- frame_done  output  1  one-cycle pulse on every frame boundary.

Behaviour:
Reset (asynchronous, active-high):
- prescaler=0, scanout=0, segout=8'hFF, grant=0, busy=0, frame_done=0.
- rr_ptr=0, hold_cnt=0, frame buffer all 1s, state=IDLE.

Digit timing:
- tick is asserted when prescaler==SCAN_DIV-1; the prescaler then wraps to 0.
- On tick, scanout <= scanout+1, wrapping 7->0.
- A frame boundary (fb) is a tick with scanout==7.
- frame_done=1 for exactly the cycle after fb, alongside scanout==0.

segout:
- Registered; updates only on tick.
- Becomes {1'b1, buf[next scanout]} when an owner exists, else 8'hFF.
- On fb it takes digit 0 of the newly latched buffer in that same tick, so every frame is internally consistent.

States:
- IDLE: grant=0, segout blank.
  - At fb: if req!=0, grant the first set req[k] searching k = rr_ptr, rr_ptr+1, ... mod 4.
  - Latch frame_in[k] into buf, hold_cnt=0, go to OWN.
  - Otherwise stay IDLE.
- OWN (owner o): evaluated at each fb only.
  - req[o]==0: release. Grant the next requester searching from o+1 (excluding o) if any, else go to IDLE with grant=0. Set rr_ptr=o+1.
  - hold_cnt==HOLD_FRAMES-1 and another req set: hand over to the next requester after o, rr_ptr=o+1, hold_cnt=0.
  - Otherwise: keep o, reload buf from frame_in[o] (live pattern refresh), and do hold_cnt+1 saturating at HOLD_FRAMES-1.

Timing and boundary rules:
- grant, busy and the buf load change in the same cycle as the fb tick edge, so grant is visible together with the new segout.
- A requester dropping req mid-frame keeps grant until the next fb; its latched frame finishes.
- frame_in changes mid-frame are not displayed until the next fb.
- Simultaneous requests: round-robin order only; no fixed priority.
- A new req arriving mid-frame waits for an fb; grant latency ≤ 8*SCAN_DIV cycles in IDLE.
- A single requester holds the display indefinitely, with no idle gap.
- Reset mid-frame: all outputs return to reset values immediately. The scan restarts at digit 0; the first possible grant is at cycle 8*SCAN_DIV after reset release.
- grant is always one-hot or zero; busy == |grant.

Test Plan:
1. Apply reset, hold 10 cycles, release, req=0 -> segout=8'hFF, scanout=0, grant=0, busy=0. With SCAN_DIV=4, scanout increments every 4 cycles and frame_done pulses every 32 cycles.
2. SCAN_DIV=4. After reset, req=4'b0001, frame0 digit d = 7'h40|d -> grant=4'b0001 at the first fb (cycle 32). segout sequence is 8'hC0..8'hC7 with scanout 0..7, each held 4 cycles.
3. HOLD_FRAMES=2, req=4'b0101 from reset -> grant 0001 for frames 1-2, 0100 for frames 3-4, then 0001 again. Changes occur only on cycles where scanout returns to 0.
4. Owner 0 active, drop req[0] at scanout=3 with req[2]=1 -> grant=0001 and buf0 digits continue through scanout=7. grant=0100 from the next fb; busy never drops.
5. Owner 1 active, change frame_in for requester 1 at scanout=5 -> digits 5..7 still show the old pattern. The new pattern appears from digit 0 of the next frame.
6. Owner active mid-frame, assert reset for 1 cycle -> segout=8'hFF, grant=0, scanout=0 immediately. The re-grant occurs exactly 8*SCAN_DIV cycles after release.
